// File: rtl/id_token_scanner_if.sv
// Character stream in, word-token results out, for id_token_scanner.
// The scanner sits on the slave side; whoever feeds characters uses master.
interface id_token_scanner_if #(
   parameter int LEN_W = 5,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic [7:0]       char;
   logic             out;
   logic             tok_done;
   logic             tok_match;
   logic [LEN_W-1:0] tok_len;
   logic [CNT_W-1:0] tok_cnt;

   modport master (
      output in_valid,
      output char,
      input  out,
      input  tok_done,
      input  tok_match,
      input  tok_len,
      input  tok_cnt
   );

   modport slave (
      input  in_valid,
      input  char,
      output out,
      output tok_done,
      output tok_match,
      output tok_len,
      output tok_cnt
   );
endinterface

// File: rtl/id_token_scanner.sv
// Identifier scanner: flags a letter-run/digit-run suffix on an ASCII stream and
// segments it into delimiter-separated words, reporting each word's match and length.
module id_token_scanner #(
   parameter int MIN_ALPHA = 1,
   parameter int MIN_DIGIT = 1,
   parameter int MAX_LEN   = 16,
   parameter int LEN_W     = 5,
   parameter int CNT_W     = 8
) (
   input logic               clk,
   input logic               reset,
   id_token_scanner_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALPHA = 2'd1,
      DIGIT = 2'd2
   } stateT;

   localparam logic [LEN_W-1:0] MinAlphaL = LEN_W'(MIN_ALPHA);
   localparam logic [LEN_W-1:0] MinDigitL = LEN_W'(MIN_DIGIT);
   localparam logic [LEN_W-1:0] MaxLenL   = LEN_W'(MAX_LEN);

   stateT            r_state, w_stateNext;
   logic [LEN_W-1:0] r_aRun, w_aRunNext;
   logic [LEN_W-1:0] r_dRun, w_dRunNext;
   logic [LEN_W-1:0] r_wLen, w_wLenNext;
   logic [LEN_W-1:0] r_tokLen, w_tokLenNext;
   logic [CNT_W-1:0] r_tokCnt, w_tokCntNext;
   logic             r_tokDone, w_tokDoneNext;
   logic             r_tokMatch, w_tokMatchNext;
   logic             w_isDigit, w_isAlpha, w_out;

   function automatic logic [LEN_W-1:0] satInc(input logic [LEN_W-1:0] v);
      return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
   endfunction

   always_comb begin
      w_isDigit = (bus.char >= 8'd48) && (bus.char <= 8'd57);
      w_isAlpha = ((bus.char >= 8'd65) && (bus.char <= 8'd90)) ||
                  ((bus.char >= 8'd97) && (bus.char <= 8'd122));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_aRun     <= '0;
         r_dRun     <= '0;
         r_wLen     <= '0;
         r_tokLen   <= '0;
         r_tokCnt   <= '0;
         r_tokDone  <= 1'b0;
         r_tokMatch <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_aRun     <= w_aRunNext;
         r_dRun     <= w_dRunNext;
         r_wLen     <= w_wLenNext;
         r_tokLen   <= w_tokLenNext;
         r_tokCnt   <= w_tokCntNext;
         r_tokDone  <= w_tokDoneNext;
         r_tokMatch <= w_tokMatchNext;
      end
   end

   // Token pulse and match flag are rebuilt every cycle; everything else holds unless a char is consumed.
   always_comb begin
      w_stateNext    = r_state;
      w_aRunNext     = r_aRun;
      w_dRunNext     = r_dRun;
      w_wLenNext     = r_wLen;
      w_tokLenNext   = r_tokLen;
      w_tokCntNext   = r_tokCnt;
      w_tokDoneNext  = 1'b0;
      w_tokMatchNext = 1'b0;

      if (bus.in_valid) begin
         if (w_isDigit || w_isAlpha) begin
            w_wLenNext = satInc(r_wLen);
            case (r_state)
               IDLE: begin
                  if (w_isAlpha) begin
                     w_stateNext = ALPHA;
                     w_aRunNext  = LEN_W'(1);
                  end
               end
               ALPHA: begin
                  if (w_isAlpha) begin
                     w_aRunNext = satInc(r_aRun);
                  end else begin
                     w_stateNext = DIGIT;
                     w_dRunNext  = LEN_W'(1);
                  end
               end
               DIGIT: begin
                  if (w_isDigit) begin
                     w_dRunNext = satInc(r_dRun);
                  end else begin
                     w_stateNext = ALPHA;
                     w_aRunNext  = LEN_W'(1);
                     w_dRunNext  = '0;
                  end
               end
               default: begin
                  w_stateNext = IDLE;
               end
            endcase
         end else begin
            w_stateNext = IDLE;
            w_aRunNext  = '0;
            w_dRunNext  = '0;
            w_wLenNext  = '0;
            // The match decision uses the flag as it stood before this delimiter.
            if (r_wLen != '0) begin
               w_tokDoneNext  = 1'b1;
               w_tokLenNext   = r_wLen;
               w_tokMatchNext = w_out && (r_wLen <= MaxLenL);
               if (w_tokMatchNext && (r_tokCnt != {CNT_W{1'b1}})) begin
                  w_tokCntNext = r_tokCnt + CNT_W'(1);
               end
            end
         end
      end
   end

   always_comb begin
      w_out = (r_state == DIGIT) && (r_aRun >= MinAlphaL) && (r_dRun >= MinDigitL);
      bus.out       = w_out;
      bus.tok_done  = r_tokDone;
      bus.tok_match = r_tokMatch;
      bus.tok_len   = r_tokLen;
      bus.tok_cnt   = r_tokCnt;
   end

endmodule

// File: tb/tb_id_token_scanner.sv
// Bench for id_token_scanner: three configurations fed directed strings; token
// results are checked by per-instance monitors against queued expectations.
module tb_id_token_scanner;

   typedef struct {
      bit match;
      int len;
      int cnt;
   } tokT;

   logic       clk = 1'b0;
   logic [2:0] rst;
   int         total = 0;
   int         bad   = 0;
   tokT        q0[$];
   tokT        q1[$];
   tokT        q2[$];

   always #5 clk = ~clk;

   id_token_scanner_if #(.LEN_W(5), .CNT_W(8)) bus0 ();
   id_token_scanner_if #(.LEN_W(5), .CNT_W(8)) bus1 ();
   id_token_scanner_if #(.LEN_W(5), .CNT_W(2)) bus2 ();

   id_token_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .MAX_LEN(16), .LEN_W(5), .CNT_W(8)) u0 (
      .clk(clk), .reset(rst[0]), .bus(bus0.slave));
   id_token_scanner #(.MIN_ALPHA(2), .MIN_DIGIT(2), .MAX_LEN(16), .LEN_W(5), .CNT_W(8)) u1 (
      .clk(clk), .reset(rst[1]), .bus(bus1.slave));
   id_token_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .MAX_LEN(16), .LEN_W(5), .CNT_W(2)) u2 (
      .clk(clk), .reset(rst[2]), .bus(bus2.slave));

   task automatic drive(input int d, input logic v, input byte c);
      case (d)
         0:       begin bus0.in_valid = v; bus0.char = c; end
         1:       begin bus1.in_valid = v; bus1.char = c; end
         default: begin bus2.in_valid = v; bus2.char = c; end
      endcase
   endtask

   function automatic logic getOut(input int d);
      case (d)
         0:       return bus0.out;
         1:       return bus1.out;
         default: return bus2.out;
      endcase
   endfunction

   task automatic checkVal(input string name, input int d, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s u%0d: got %0d want %0d", name, d, got, want);
      end
   endtask

   task automatic pushTok(input int d, input bit m, input int len, input int cnt);
      tokT e;
      e.match = m;
      e.len   = len;
      e.cnt   = cnt;
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Feeds a string back-to-back (or with two idle cycles after each char) and checks out after every char.
   task automatic applyStimulus(input int d, input string s, input string outs, input bit gaps);
      int want;
      for (int i = 0; i < s.len(); i++) begin
         drive(d, 1'b1, s[i]);
         @(posedge clk);
         #1;
         want = (outs[i] == 8'h31) ? 1 : 0;
         checkVal($sformatf("out[%0d]", i), d, int'(getOut(d)), want);
         if (gaps) begin
            drive(d, 1'b0, 8'h7a);
            repeat (2) begin
               @(posedge clk);
               #1;
               checkVal($sformatf("outHold[%0d]", i), d, int'(getOut(d)), want);
            end
         end
      end
      drive(d, 1'b0, 8'h20);
   endtask

   task automatic checkOutput(input int d, input logic done, input logic m, input int len, input int cnt);
      tokT e;
      int  n;
      if (done) begin
         n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
         total++;
         if (n == 0) begin
            bad++;
            $display("[TB] FAIL tokUnexpected u%0d: got pulse len=%0d want none", d, len);
         end else begin
            case (d)
               0:       e = q0.pop_front();
               1:       e = q1.pop_front();
               default: e = q2.pop_front();
            endcase
            checkVal("tokMatch", d, int'(m), int'(e.match));
            checkVal("tokLen", d, len, e.len);
            checkVal("tokCnt", d, cnt, e.cnt);
         end
      end else if (m !== 1'b0) begin
         total++;
         bad++;
         $display("[TB] FAIL tokMatchIdle u%0d: got %0b want 0", d, m);
      end
   endtask

   always @(negedge clk) checkOutput(0, bus0.tok_done, bus0.tok_match, int'(bus0.tok_len), int'(bus0.tok_cnt));
   always @(negedge clk) checkOutput(1, bus1.tok_done, bus1.tok_match, int'(bus1.tok_len), int'(bus1.tok_cnt));
   always @(negedge clk) checkOutput(2, bus2.tok_done, bus2.tok_match, int'(bus2.tok_len), int'(bus2.tok_cnt));

   initial begin
      string longS;
      string longO;

      rst = 3'b111;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h20);
      repeat (2) @(posedge clk);
      #1;
      rst = 3'b000;

      checkVal("rstOut", 0, int'(bus0.out), 0);
      checkVal("rstDone", 0, int'(bus0.tok_done), 0);
      checkVal("rstMatch", 0, int'(bus0.tok_match), 0);
      checkVal("rstLen", 0, int'(bus0.tok_len), 0);
      checkVal("rstCnt", 0, int'(bus0.tok_cnt), 0);

      pushTok(0, 1'b1, 2, 1);
      applyStimulus(0, "a1 ", "010", 1'b0);
      pushTok(0, 1'b1, 7, 2);
      applyStimulus(0, "12ab3c4;", "00001010", 1'b0);

      applyStimulus(0, "  ,,x9", "000001", 1'b1);
      pushTok(0, 1'b1, 2, 3);
      applyStimulus(0, " ", "0", 1'b0);

      longS = "";
      longO = "";
      for (int i = 0; i < 40; i++) begin
         longS = {longS, "a"};
         longO = {longO, "0"};
      end
      longS = {longS, "7 "};
      longO = {longO, "10"};
      pushTok(0, 1'b0, 31, 3);
      applyStimulus(0, longS, longO, 1'b0);

      pushTok(1, 1'b0, 3, 0);
      pushTok(1, 1'b0, 3, 0);
      pushTok(1, 1'b1, 4, 1);
      applyStimulus(1, "a12 ab1 ab12 ", "0000000000010", 1'b0);

      pushTok(2, 1'b1, 2, 1);
      pushTok(2, 1'b1, 2, 2);
      pushTok(2, 1'b1, 2, 3);
      pushTok(2, 1'b1, 2, 3);
      pushTok(2, 1'b1, 2, 3);
      applyStimulus(2, "a1 a1 a1 a1 a1 ", "010010010010010", 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // A reset arriving mid-word with a valid char must drop the word silently.
      applyStimulus(2, "ab", "00", 1'b0);
      drive(2, 1'b1, 8'h63);
      rst[2] = 1'b1;
      @(posedge clk);
      #1;
      rst[2] = 1'b0;
      drive(2, 1'b0, 8'h20);
      checkVal("midRstOut", 2, int'(bus2.out), 0);
      checkVal("midRstDone", 2, int'(bus2.tok_done), 0);
      checkVal("midRstMatch", 2, int'(bus2.tok_match), 0);
      checkVal("midRstLen", 2, int'(bus2.tok_len), 0);
      checkVal("midRstCnt", 2, int'(bus2.tok_cnt), 0);
      applyStimulus(2, " ", "0", 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkVal("pending0", 0, q0.size(), 0);
      checkVal("pending1", 1, q1.size(), 0);
      checkVal("pending2", 2, q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
